// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, the empty instruction and the fetch entry layout.
package cpu_pkg;

  localparam int ADDR_W     = 4;
  localparam int INSTR_W    = 12;
  localparam int IMEM_DEPTH = 16;
  localparam int ENTRY_W    = INSTR_W + ADDR_W;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = {NOP_INSTR, 4'd0};

  // Sequential next address; the 4-bit result wraps 15 -> 0.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + 4'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry output/skid register pair between fetch and decode.
// The output register feeds decode; the skid register catches a returning
// fetch while the output register is stalled, so nothing is ever dropped.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_in_valid,
  input  logic [ENTRY_W-1:0] i_in_data,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [ENTRY_W-1:0] o_out_data,
  output logic               o_skid_valid
);

  logic               r_out_valid;
  logic [ENTRY_W-1:0] r_out_data;
  logic               r_skid_valid;
  logic [ENTRY_W-1:0] r_skid_data;

  logic               w_pop;
  logic               w_out_valid;
  logic [ENTRY_W-1:0] w_out_data;
  logic               w_skid_valid;
  logic [ENTRY_W-1:0] w_skid_data;

  assign w_pop = r_out_valid && i_out_ready;

  // Next-state of both registers; the older entry always moves toward decode first.
  always_comb begin
    w_out_valid  = r_out_valid;
    w_out_data   = r_out_data;
    w_skid_valid = r_skid_valid;
    w_skid_data  = r_skid_data;
    if (i_flush) begin
      // A coincident pop has already been taken by decode; everything else goes.
      w_out_valid  = 1'b0;
      w_skid_valid = 1'b0;
    end else if (!r_out_valid || w_pop) begin
      if (r_skid_valid) begin
        w_out_valid  = 1'b1;
        w_out_data   = r_skid_data;
        w_skid_valid = i_in_valid;
        if (i_in_valid) begin
          w_skid_data = i_in_data;
        end else begin
          w_skid_data = r_skid_data;
        end
      end else begin
        w_out_valid = i_in_valid;
        if (i_in_valid) begin
          w_out_data = i_in_data;
        end else begin
          w_out_data = r_out_data;
        end
      end
    end else begin
      // Output stalled: a returning fetch parks in the skid slot.
      if (i_in_valid) begin
        w_skid_valid = 1'b1;
        w_skid_data  = i_in_data;
      end else begin
        w_skid_valid = r_skid_valid;
      end
    end
  end

  // Register the buffer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= EMPTY_ENTRY;
      r_skid_valid <= 1'b0;
      r_skid_data  <= EMPTY_ENTRY;
    end else begin
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_skid_valid <= w_skid_valid;
      r_skid_data  <= w_skid_data;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, fetch issue with credit check, in-flight tag,
// branch redirect and halt. Memory has one cycle of read latency.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  input  logic               id_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt
);

  logic [ADDR_W-1:0]  r_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;

  logic               w_out_valid;
  logic               w_skid_valid;
  logic [ENTRY_W-1:0] w_out_data;
  logic [ENTRY_W-1:0] w_in_data;
  fetch_entry_t       w_out_entry;
  logic [1:0]         w_held;
  logic               w_issue;

  // Entries that will occupy the buffer after this edge, counting the fetch
  // now returning; issuing only below 2 guarantees the next return has a slot.
  assign w_held  = {1'b0, w_out_valid} + {1'b0, w_skid_valid} + {1'b0, r_inflight}
                 - {1'b0, (w_out_valid && id_ready)};
  assign w_issue = !halt && !branch_taken && (w_held < 2'd2);

  // PC, in-flight flag and its address tag; a redirect overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= 4'd0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 4'd0;
    end else if (branch_taken) begin
      r_pc       <= branch_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= pc_incr(r_pc);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  assign w_in_data = {instruction, r_inflight_pc};

  fetch_skid_buffer u_skid (
    .clk          (clk),
    .rst          (reset),
    .i_flush      (branch_taken),
    .i_in_valid   (r_inflight),
    .i_in_data    (w_in_data),
    .i_out_ready  (id_ready),
    .o_out_valid  (w_out_valid),
    .o_out_data   (w_out_data),
    .o_skid_valid (w_skid_valid)
  );

  assign w_out_entry  = fetch_entry_t'(w_out_data);
  assign read_address = r_pc;
  assign if_instr     = w_out_entry.instr;
  assign if_pc        = w_out_entry.pc;
  assign if_valid     = w_out_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch plus a random
// id_ready/branch run with an in-order delivery scoreboard.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [3:0]  read_address;
  logic [11:0] instruction;
  logic [11:0] if_instr;
  logic [3:0]  if_pc;
  logic        if_valid;
  logic        id_ready;
  logic        branch_taken;
  logic [3:0]  branch_target;
  logic        halt;

  logic [11:0] mem [16];

  int n_checks;
  int n_fail;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .read_address  (read_address),
    .instruction   (instruction),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .id_ready      (id_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the address.
  always_ff @(posedge clk) instruction <= mem[read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    id_ready      = 1'b1;
    halt          = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 4'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pc(input logic [3:0] p);
    int n;
    n = 0;
    while (!(if_valid && if_pc == p) && n < 40) begin
      tick();
      n++;
    end
    check("wait_pc", 32'(if_valid && if_pc == p), 32'd1);
  endtask

  logic [3:0]  exp_pc;
  logic        prev_hold;
  logic [3:0]  prev_pc;
  logic [11:0] prev_instr;
  int          n_deliv;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 16; k++) mem[k] = 12'h100 + 12'(k);

    // Reset state.
    reset = 1'b1; id_ready = 1'b1; halt = 1'b0; branch_taken = 1'b0; branch_target = 4'd0;
    #2;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", 32'(if_instr), 32'd0);
    check("rst_pc",    32'(if_pc),    32'd0);
    check("rst_raddr", 32'(read_address), 32'd0);

    // Streaming with wrap: 2-cycle first latency, then one per cycle.
    do_reset();
    tick();
    check("lat_not_yet", 32'(if_valid), 32'd0);
    tick();
    for (int k = 0; k < 20; k++) begin
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_pc",    32'(if_pc), 32'(k % 16));
      check("stream_instr", 32'(if_instr), 32'(12'h100 + 12'(k % 16)));
      tick();
    end

    // Stall decode for 5 cycles at if_pc=3.
    do_reset();
    wait_pc(4'd3);
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc",    32'(if_pc), 32'd3);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_raddr", 32'(read_address), 32'd5);
    end
    id_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      tick();
      check("release_pc",    32'(if_pc), 32'(i));
      check("release_valid", 32'(if_valid), 32'd1);
    end

    // Branch to 9 while 4 is presented and 5 is in flight.
    do_reset();
    wait_pc(4'd4);
    branch_taken = 1'b1; branch_target = 4'd9;
    tick();
    branch_taken = 1'b0;
    check("br_flush_valid", 32'(if_valid), 32'd0);
    check("br_raddr",       32'(read_address), 32'd9);
    tick();
    check("br_lat_valid", 32'(if_valid), 32'd0);
    tick();
    check("br_valid", 32'(if_valid), 32'd1);
    check("br_pc",    32'(if_pc), 32'd9);
    check("br_instr", 32'(if_instr), 32'h109);
    tick();
    check("br_next_pc", 32'(if_pc), 32'd10);

    // Halt at if_pc=2: only 3 drains, then idle with PC parked at 4.
    do_reset();
    wait_pc(4'd2);
    halt = 1'b1;
    tick();
    check("halt_drain_valid", 32'(if_valid), 32'd1);
    check("halt_drain_pc",    32'(if_pc), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_idle_valid", 32'(if_valid), 32'd0);
      check("halt_raddr",      32'(read_address), 32'd4);
    end
    halt = 1'b0;
    tick();
    check("resume_lat_valid", 32'(if_valid), 32'd0);
    tick();
    check("resume_pc",    32'(if_pc), 32'd4);
    check("resume_instr", 32'(if_instr), 32'h104);

    // Branch while halted: loads PC, flushes, no issue until halt drops.
    do_reset();
    wait_pc(4'd2);
    halt = 1'b1; branch_taken = 1'b1; branch_target = 4'd12;
    tick();
    branch_taken = 1'b0;
    check("hbr_valid", 32'(if_valid), 32'd0);
    check("hbr_raddr", 32'(read_address), 32'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hbr_hold_valid", 32'(if_valid), 32'd0);
      check("hbr_hold_raddr", 32'(read_address), 32'd12);
    end
    halt = 1'b0;
    tick();
    check("hbr_issue_raddr", 32'(read_address), 32'd13);
    tick();
    check("hbr_pc",    32'(if_pc), 32'd12);
    check("hbr_instr", 32'(if_instr), 32'h10c);

    // Asynchronous reset while output and skid are both full.
    do_reset();
    wait_pc(4'd3);
    id_ready = 1'b0;
    tick();
    check("pre_rst_valid", 32'(if_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_raddr", 32'(read_address), 32'd0);
    tick();
    id_ready = 1'b1;
    reset = 1'b0;
    tick();
    check("post_rst_lat", 32'(if_valid), 32'd0);
    tick();
    check("post_rst_valid", 32'(if_valid), 32'd1);
    check("post_rst_pc",    32'(if_pc), 32'd0);
    check("post_rst_instr", 32'(if_instr), 32'h100);

    // Random decode backpressure and branches against an order scoreboard.
    do_reset();
    exp_pc    = 4'd0;
    prev_hold = 1'b0;
    prev_pc   = 4'd0;
    prev_instr = 12'h000;
    n_deliv   = 0;
    for (int c = 0; c < 200; c++) begin
      id_ready      = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 4'($urandom_range(0, 15));
      if (prev_hold) begin
        check("rnd_hold_valid", 32'(if_valid), 32'd1);
        check("rnd_hold_pc",    32'(if_pc), 32'(prev_pc));
        check("rnd_hold_instr", 32'(if_instr), 32'(prev_instr));
      end
      if (if_valid && id_ready) begin
        check("rnd_order_pc", 32'(if_pc), 32'(exp_pc));
        check("rnd_instr",    32'(if_instr), 32'(12'h100 + {8'd0, exp_pc}));
        exp_pc = exp_pc + 4'd1;
        n_deliv++;
      end
      if (branch_taken) exp_pc = branch_target;
      prev_hold  = if_valid && !id_ready && !branch_taken;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      tick();
    end
    branch_taken = 1'b0;
    id_ready     = 1'b1;
    check("rnd_progress", 32'(n_deliv >= 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
